// File: rtl/ltc2308_pkg.sv
// ltc2308_pkg
// Shared definitions for the LTC2308 scan controller: config-word bit
// positions, the per-frame FSM state type, and helpers to build a config
// word and to walk an enabled-channel mask.
package ltc2308_pkg;

  // Bit positions inside the 6-bit config word (bit 5 is shifted out first)
  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_SHIFT,
    ST_GAP
  } frame_state_e;

  // Single-ended config word for channel ch; sleep is never requested.
  function automatic logic [5:0] ch_to_cfg(input logic [2:0] ch, input logic uni);
    logic [5:0] w;
    w          = '0;
    w[CFG_SD]  = 1'b1;
    w[CFG_OS]  = ch[0];
    w[CFG_S1]  = ch[2];
    w[CFG_S0]  = ch[1];
    w[CFG_UNI] = uni;
    w[CFG_SLP] = 1'b0;
    return w;
  endfunction

  // Lowest enabled channel whose index is >= cur. Returns {found, ch}.
  // cur may be 8, meaning "past the last channel", which always misses.
  function automatic logic [3:0] next_ch(input logic [7:0] mask, input logic [3:0] cur);
    logic [3:0] r;
    r = '0;
    // Walking downwards lets the lowest qualifying index win
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (i >= int'(cur))) begin
        r = {1'b1, 3'(i)};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ltc2308_frame.sv
// ltc2308_frame
// Runs one LTC2308 conversion frame: CONV (CONVST pulse, then wait for the
// conversion), SHIFT (12 SCK periods, config out on SDI, result in on SDO)
// and GAP (2 idle cycles). In the last GAP cycle frame_done is high; if
// frame_go is also high the next frame starts back to back.
// Ports:
//   clk, reset_n       clock, async active-low reset
//   frame_go, cfg      start a frame with this 6-bit config word
//   frame_done         high during the last GAP cycle
//   data_valid, data   one-cycle pulse when the 12th SDO bit has been captured
//   convst, sck, sdi   ADC control outputs (registered)
//   sdo                ADC serial data input
module ltc2308_frame
  import ltc2308_pkg::*;
#(
  parameter int SCK_DIV     = 2,
  parameter int CONV_CYCLES = 80
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_go,
  input  logic [5:0]  cfg,
  input  logic        sdo,
  output logic        frame_done,
  output logic        data_valid,
  output logic [11:0] data,
  output logic        convst,
  output logic        sck,
  output logic        sdi
);

  localparam logic [15:0] CONV_LAST = 16'(CONV_CYCLES - 1);
  localparam logic [15:0] HALF_LAST = 16'(SCK_DIV - 1);

  frame_state_e state, state_d;
  logic [15:0]  cnt, cnt_d;
  logic [3:0]   bit_idx, bit_idx_d;
  logic [5:0]   cfg_sh, cfg_sh_d;
  logic [11:0]  shreg, shreg_d;
  logic         convst_d, sck_d, sdi_d, data_valid_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      cfg_sh     <= '0;
      shreg      <= '0;
      convst     <= 1'b0;
      sck        <= 1'b0;
      sdi        <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bit_idx    <= bit_idx_d;
      cfg_sh     <= cfg_sh_d;
      shreg      <= shreg_d;
      convst     <= convst_d;
      sck        <= sck_d;
      sdi        <= sdi_d;
      data_valid <= data_valid_d;
    end
  end

  // cnt counts CONV cycles, SCK half-period cycles and GAP cycles in turn.
  // cfg_sh is shifted left as bits go out, so SDI naturally falls to 0
  // once all six config bits have been sent.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    bit_idx_d    = bit_idx;
    cfg_sh_d     = cfg_sh;
    shreg_d      = shreg;
    convst_d     = 1'b0;
    sck_d        = sck;
    sdi_d        = sdi;
    data_valid_d = 1'b0;
    frame_done   = 1'b0;

    case (state)
      ST_IDLE: begin
        sck_d = 1'b0;
        sdi_d = 1'b0;
        if (frame_go) begin
          state_d  = ST_CONV;
          cnt_d    = '0;
          cfg_sh_d = cfg;
          convst_d = 1'b1;
        end
      end

      ST_CONV: begin
        if (cnt == CONV_LAST) begin
          // First config bit goes out a full half period before the first rise
          state_d   = ST_SHIFT;
          cnt_d     = '0;
          bit_idx_d = '0;
          sck_d     = 1'b0;
          sdi_d     = cfg_sh[5];
          cfg_sh_d  = {cfg_sh[4:0], 1'b0};
        end else begin
          cnt_d    = cnt + 16'd1;
          convst_d = (cnt == 16'd0);
        end
      end

      ST_SHIFT: begin
        if (cnt != HALF_LAST) begin
          cnt_d = cnt + 16'd1;
        end else begin
          cnt_d = '0;
          if (!sck) begin
            // Rising edge: sample SDO on the same clk edge that raises SCK
            sck_d   = 1'b1;
            shreg_d = {shreg[10:0], sdo};
            if (bit_idx == 4'd11) begin
              data_valid_d = 1'b1;
            end
          end else begin
            sck_d = 1'b0;
            if (bit_idx == 4'd11) begin
              state_d = ST_GAP;
              sdi_d   = 1'b0;
            end else begin
              bit_idx_d = bit_idx + 4'd1;
              sdi_d     = cfg_sh[5];
              cfg_sh_d  = {cfg_sh[4:0], 1'b0};
            end
          end
        end
      end

      ST_GAP: begin
        sck_d = 1'b0;
        sdi_d = 1'b0;
        if (cnt == 16'd1) begin
          frame_done = 1'b1;
          if (frame_go) begin
            state_d  = ST_CONV;
            cnt_d    = '0;
            cfg_sh_d = cfg;
            convst_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign data = shreg;

endmodule

// File: rtl/ltc2308_scan_ctrl.sv
// ltc2308_scan_ctrl
// Scans every channel enabled in a latched mask, lowest first, one LTC2308
// frame per channel plus one trailing frame to flush the ADC's one-frame
// config/result pipeline. Each result is tagged with the channel that was
// configured in the frame before the one that returned it.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   start, continuous, ch_mask    scan request, auto-restart, channel enables
//   uni                           unipolar bit for every config word
//   adc_convst/sck/sdi, adc_sdo   ADC serial interface
//   busy                          high from scan start until scan_done
//   result_valid/ch/data          tagged result strobe
//   scan_done                     strobe in the last cycle of a scan
module ltc2308_scan_ctrl
  import ltc2308_pkg::*;
#(
  parameter int SCK_DIV     = 2,
  parameter int CONV_CYCLES = 80
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        continuous,
  input  logic [7:0]  ch_mask,
  input  logic        uni,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo,
  output logic        busy,
  output logic        result_valid,
  output logic [2:0]  result_ch,
  output logic [11:0] result_data,
  output logic        scan_done
);

  logic [7:0]  mask_q;
  logic        uni_q;
  logic [2:0]  cur_ch;
  logic [2:0]  prev_ch;
  logic        first_q;
  logic        dummy_q;

  logic        frame_go;
  logic [5:0]  cfg_next;
  logic        frame_done;
  logic        data_valid;
  logic [11:0] frame_data;
  logic        load_scan;
  logic        advance;
  logic        finish;
  logic [3:0]  first_in;
  logic [3:0]  first_q_ch;
  logic [3:0]  nxt;

  ltc2308_frame #(
    .SCK_DIV     (SCK_DIV),
    .CONV_CYCLES (CONV_CYCLES)
  ) u_frame (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_go   (frame_go),
    .cfg        (cfg_next),
    .sdo        (adc_sdo),
    .frame_done (frame_done),
    .data_valid (data_valid),
    .data       (frame_data),
    .convst     (adc_convst),
    .sck        (adc_sck),
    .sdi        (adc_sdi)
  );

  // Frame sequencing is decided combinationally so the first frame starts on
  // the edge that sees start, and later frames follow the GAP with no
  // dead cycle. The trailing (dummy) frame re-sends the first channel.
  always_comb begin
    frame_go   = 1'b0;
    cfg_next   = '0;
    load_scan  = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    first_in   = next_ch(ch_mask, 4'd0);
    first_q_ch = next_ch(mask_q, 4'd0);
    nxt        = next_ch(mask_q, {1'b0, cur_ch} + 4'd1);

    if (!busy) begin
      if (start && (ch_mask != 8'd0)) begin
        load_scan = 1'b1;
        frame_go  = 1'b1;
        cfg_next  = ch_to_cfg(first_in[2:0], uni);
      end
    end else if (frame_done) begin
      if (dummy_q) begin
        finish = 1'b1;
        if (continuous && (ch_mask != 8'd0)) begin
          load_scan = 1'b1;
          frame_go  = 1'b1;
          cfg_next  = ch_to_cfg(first_in[2:0], uni);
        end
      end else begin
        advance  = 1'b1;
        frame_go = 1'b1;
        if (nxt[3]) begin
          cfg_next = ch_to_cfg(nxt[2:0], uni_q);
        end else begin
          cfg_next = ch_to_cfg(first_q_ch[2:0], uni_q);
        end
      end
    end
  end

  // prev_ch tags the capture of the current frame; first_q suppresses the
  // capture of frame 0, which belongs to no channel of this scan.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy         <= 1'b0;
      mask_q       <= '0;
      uni_q        <= 1'b0;
      cur_ch       <= '0;
      prev_ch      <= '0;
      first_q      <= 1'b0;
      dummy_q      <= 1'b0;
      result_valid <= 1'b0;
      result_ch    <= '0;
      result_data  <= '0;
    end else begin
      result_valid <= 1'b0;
      if (load_scan) begin
        busy    <= 1'b1;
        mask_q  <= ch_mask;
        uni_q   <= uni;
        cur_ch  <= first_in[2:0];
        first_q <= 1'b1;
        dummy_q <= 1'b0;
      end else if (finish) begin
        busy    <= 1'b0;
        dummy_q <= 1'b0;
      end else if (advance) begin
        prev_ch <= cur_ch;
        first_q <= 1'b0;
        if (nxt[3]) begin
          cur_ch <= nxt[2:0];
        end else begin
          dummy_q <= 1'b1;
        end
      end

      if (data_valid && busy && !first_q) begin
        result_valid <= 1'b1;
        result_ch    <= prev_ch;
        result_data  <= frame_data;
      end
    end
  end

  assign scan_done = busy && frame_done && dummy_q;

endmodule

// File: tb/tb_ltc2308_scan_ctrl.sv
// tb_ltc2308_scan_ctrl
// Directed bench for ltc2308_scan_ctrl with a behavioural LTC2308: the model
// decodes each config word from SDI and returns, in the next frame, a value
// derived from that channel (ch0 12'hA5C, ch1 12'hB6D, ch2 12'hC7E,
// ch7 12'h1D3).
module tb_ltc2308_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        continuous;
  logic [7:0]  ch_mask;
  logic        uni;
  logic        adc_convst;
  logic        adc_sck;
  logic        adc_sdi;
  logic        adc_sdo;
  logic        busy;
  logic        result_valid;
  logic [2:0]  result_ch;
  logic [11:0] result_data;
  logic        scan_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  ltc2308_scan_ctrl #(
    .SCK_DIV     (2),
    .CONV_CYCLES (80)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .continuous   (continuous),
    .ch_mask      (ch_mask),
    .uni          (uni),
    .adc_convst   (adc_convst),
    .adc_sck      (adc_sck),
    .adc_sdi      (adc_sdi),
    .adc_sdo      (adc_sdo),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ch    (result_ch),
    .result_data  (result_data),
    .scan_done    (scan_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // ADC model: pipeline of one frame, SDO advanced on SCK falling edges
  logic [11:0] adc_word = 12'hFFF;
  logic [5:0]  cfg_sh = '0;
  int          cfg_cnt = 0;
  logic [2:0]  adc_ch = '0;
  logic        have_ch = 1'b0;
  logic        m_sck_q = 1'b0;
  logic        m_conv_q = 1'b0;
  logic [5:0]  cfg_log[$];

  function automatic logic [11:0] adcValue(input logic [2:0] ch);
    return 12'hA5C + 12'h111 * {9'd0, ch};
  endfunction

  initial adc_sdo = 1'b0;

  always @(negedge clk) begin
    if (adc_convst && !m_conv_q) begin
      adc_word = have_ch ? adcValue(adc_ch) : 12'hFFF;
      adc_sdo  = adc_word[11];
      cfg_cnt  = 0;
    end
    if (adc_sck && !m_sck_q && cfg_cnt < 6) begin
      cfg_sh = {cfg_sh[4:0], adc_sdi};
      cfg_cnt++;
      if (cfg_cnt == 6) begin
        cfg_log.push_back(cfg_sh);
        adc_ch  = {cfg_sh[3], cfg_sh[2], cfg_sh[4]};
        have_ch = 1'b1;
      end
    end
    if (!adc_sck && m_sck_q) begin
      adc_word = {adc_word[10:0], 1'b0};
      adc_sdo  = adc_word[11];
    end
    m_sck_q  = adc_sck;
    m_conv_q = adc_convst;
  end

  // Output monitor
  logic        sck_q = 1'b0;
  logic        convst_q = 1'b0;
  int          rise_cnt = 0;
  int          last12 = 0;
  int          conv_times[$];
  int          done_cyc[$];
  int          done_cnt = 0;
  logic [14:0] res_q[$];

  always @(negedge clk) begin
    if (reset_n) begin
      if (adc_convst && !convst_q) begin
        rise_cnt = 0;
        conv_times.push_back(cyc);
      end
      if (adc_sck && !sck_q) begin
        rise_cnt++;
        if (rise_cnt == 12) last12 = cyc;
      end
      if (result_valid) begin
        res_q.push_back({result_ch, result_data});
        checkOutput("rv_latency", cyc - last12, 1);
      end
      if (scan_done) begin
        done_cnt++;
        done_cyc.push_back(cyc);
      end
      sck_q    = adc_sck;
      convst_q = adc_convst;
    end
  end

  logic [14:0] exp_res[8];
  logic [5:0]  exp_cfg[8];

  task automatic clearLogs();
    res_q.delete();
    cfg_log.delete();
    conv_times.delete();
    done_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic applyStimulus(input logic [7:0] m, input logic u, input logic c);
    @(negedge clk);
    ch_mask    = m;
    uni        = u;
    continuous = c;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitScanDone(input int budget, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!scan_done && n < budget);
    checkOutput(tag, scan_done, 1);
  endtask

  task automatic checkResults(input int n, input string tag);
    checkOutput({tag, "_res_count"}, res_q.size(), n);
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_res"}, (i < res_q.size()) ? res_q[i] : 15'h7FFF, exp_res[i]);
    end
  endtask

  task automatic checkCfg(input int n, input string tag);
    checkOutput({tag, "_cfg_count"}, cfg_log.size(), n);
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_cfg"}, (i < cfg_log.size()) ? cfg_log[i] : 6'h3F, exp_cfg[i]);
    end
  endtask

  task automatic checkFrames(input int n, input string tag);
    checkOutput({tag, "_frames"}, conv_times.size(), n);
    for (int i = 1; i < conv_times.size(); i++) begin
      checkOutput({tag, "_spacing"}, conv_times[i] - conv_times[i-1], 130);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          t0;
    int          n;
    logic [7:0]  bad;

    reset_n    = 1'b0;
    start      = 1'b0;
    continuous = 1'b0;
    ch_mask    = 8'h00;
    uni        = 1'b0;

    // Reset held with random inputs
    bad = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start      = 1'($urandom_range(0, 1));
      continuous = 1'($urandom_range(0, 1));
      ch_mask    = 8'($urandom);
      uni        = 1'($urandom_range(0, 1));
      bad = bad | {adc_convst, adc_sck, adc_sdi, busy, result_valid, scan_done,
                   |result_ch, |result_data};
    end
    checkOutput("reset_outputs", bad, 0);
    checkOutput("reset_result", {result_ch, result_data}, 0);
    start      = 1'b0;
    continuous = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_busy", busy, 0);

    // Single channel
    clearLogs();
    applyStimulus(8'h01, 1'b1, 1'b0);
    t0 = cyc;
    checkOutput("single_convst_latency", adc_convst, 1);
    checkOutput("single_busy", busy, 1);
    waitScanDone(400, "single_done_seen");
    checkOutput("single_done_time", cyc - t0, 259);
    checkOutput("single_busy_at_done", busy, 1);
    @(negedge clk);
    checkOutput("single_busy_after", busy, 0);
    exp_res[0] = {3'd0, 12'hA5C};
    checkResults(1, "single");
    exp_cfg[0] = 6'b100010;
    exp_cfg[1] = 6'b100010;
    checkCfg(2, "single");
    checkFrames(2, "single");
    checkOutput("single_done_cnt", done_cnt, 1);

    // Three channels, with a start/mask/uni change mid-scan that must be ignored
    clearLogs();
    applyStimulus(8'h85, 1'b1, 1'b0);
    t0 = cyc;
    repeat (200) @(negedge clk);
    ch_mask = 8'hFF;
    uni     = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitScanDone(600, "three_done_seen");
    checkOutput("three_done_time", cyc - t0, 519);
    @(negedge clk);
    checkOutput("three_busy_after", busy, 0);
    exp_res[0] = {3'd0, 12'hA5C};
    exp_res[1] = {3'd2, 12'hC7E};
    exp_res[2] = {3'd7, 12'h1D3};
    checkResults(3, "three");
    exp_cfg[0] = 6'b100010;
    exp_cfg[1] = 6'b100110;
    exp_cfg[2] = 6'b111110;
    exp_cfg[3] = 6'b100010;
    checkCfg(4, "three");
    checkFrames(4, "three");
    checkOutput("three_done_cnt", done_cnt, 1);

    // Start with an empty mask is ignored
    clearLogs();
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("mask0_busy", busy, 0);
    repeat (20) @(negedge clk);
    checkOutput("mask0_frames", conv_times.size(), 0);

    // Continuous, stopped during the second scan's frame 1
    clearLogs();
    applyStimulus(8'h03, 1'b0, 1'b1);
    t0 = cyc;
    repeat (560) @(negedge clk);
    continuous = 1'b0;
    waitScanDone(400, "cont_done_seen");
    checkOutput("cont_done2_time", cyc - t0, 779);
    @(negedge clk);
    checkOutput("cont_busy_after", busy, 0);
    checkOutput("cont_done1_time", (done_cyc.size() > 0) ? done_cyc[0] - t0 : -1, 389);
    repeat (300) @(negedge clk);
    checkOutput("cont_done_cnt", done_cnt, 2);
    checkOutput("cont_idle_busy", busy, 0);
    exp_res[0] = {3'd0, 12'hA5C};
    exp_res[1] = {3'd1, 12'hB6D};
    exp_res[2] = {3'd0, 12'hA5C};
    exp_res[3] = {3'd1, 12'hB6D};
    checkResults(4, "cont");
    exp_cfg[0] = 6'b100000;
    exp_cfg[1] = 6'b110000;
    exp_cfg[2] = 6'b100000;
    exp_cfg[3] = 6'b100000;
    exp_cfg[4] = 6'b110000;
    exp_cfg[5] = 6'b100000;
    checkCfg(6, "cont");
    checkFrames(6, "cont");

    // Reset after the 5th SCK rising edge of frame 0
    clearLogs();
    applyStimulus(8'h01, 1'b1, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (rise_cnt < 5 && n < 300);
    checkOutput("prerst_rise5_seen", rise_cnt, 5);
    checkOutput("prerst_sck", adc_sck, 1);
    checkOutput("prerst_sdi", adc_sdi, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_sck", adc_sck, 0);
    checkOutput("rst_sdi", adc_sdi, 0);
    checkOutput("rst_convst", adc_convst, 0);
    checkOutput("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (300) @(negedge clk);
    checkOutput("rst_no_result", res_q.size(), 0);
    checkOutput("rst_no_resume", conv_times.size(), 1);

    // Clean scan after the aborted one
    clearLogs();
    applyStimulus(8'h02, 1'b1, 1'b0);
    t0 = cyc;
    waitScanDone(400, "post_done_seen");
    checkOutput("post_done_time", cyc - t0, 259);
    exp_res[0] = {3'd1, 12'hB6D};
    checkResults(1, "post");
    exp_cfg[0] = 6'b110010;
    exp_cfg[1] = 6'b110010;
    checkCfg(2, "post");
    @(negedge clk);
    checkOutput("post_busy_after", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
